wb_pkt_scheduler: RTL and testbench



---
 rtl/wb_pkt_scheduler_if.sv | 24 ++
 rtl/wb_pkt_scheduler.sv | 143 ++++++++++++++
 tb/tb_wb_pkt_scheduler.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkt_scheduler_if.sv
// Request/grant bundle between the write-back requesters (decoder + Edge PEs)
// and the packet scheduler; master = requester side, slave = scheduler side.
interface wb_pkt_scheduler_if #(
   parameter int NUM_REQS = 5
) ();
   localparam int IDW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

   logic [NUM_REQS-1:0] reqs;
   logic [NUM_REQS-1:0] lasts;
   logic [NUM_REQS-1:0] grants;
   logic                busy;
   logic [IDW-1:0]      owner_id;
   logic                timeout_flag;

   modport master (
      output reqs, lasts,
      input  grants, busy, owner_id, timeout_flag
   );

   modport slave (
      input  reqs, lasts,
      output grants, busy, owner_id, timeout_flag
   );
endinterface

// File: rtl/wb_pkt_scheduler.sv
// Write-back packet path scheduler: round-robin burst arbiter with a bounded
// priority lane for requester 0. Optional forced release: WB_ARB_TIMEOUT_EN.
module wb_pkt_scheduler #(
   parameter int NUM_REQS     = 5,
   parameter int HIGH_PRIO0   = 1,
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_HOLD     = 64
) (
   input logic               clk,
   input logic               reset,
   wb_pkt_scheduler_if.slave bus
);
   localparam int IDW = $clog2(NUM_REQS);
   localparam int PW  = IDW + 1;
   localparam int PCW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_REQS - 1);
   localparam logic [PCW-1:0] STARVE_MAX = PCW'(STARVE_LIMIT);
   localparam logic           PRIO0_EN   = (HIGH_PRIO0 != 0);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t              state_reg;
   logic [NUM_REQS-1:0] grants_reg;
   logic                busy_reg;
   logic [IDW-1:0]      owner_reg;
   logic                timeout_reg;
   logic [IDW-1:0]      rr_ptr_reg;
   logic [PCW-1:0]      prio_cnt_reg;
`ifdef WB_ARB_TIMEOUT_EN
   localparam int HCW = $clog2(MAX_HOLD + 1);
   logic [HCW-1:0]      hold_cnt_reg;
`endif

   logic                others_waiting;
   logic                starve_override;
   logic                prio_win;
   logic [NUM_REQS-1:0] scan_mask;
   logic [NUM_REQS-1:0] rotated;
   logic                rr_found;
   logic [PW-1:0]       rr_sum;
   logic [IDW-1:0]      rr_id;
   logic [IDW-1:0]      win_id;
   logic [NUM_REQS-1:0] win_onehot;
   logic                owner_done;

   function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
      return (id == LAST_ID) ? '0 : id + IDW'(1);
   endfunction

   // The scan is done on a copy of the requests rotated so bit 0 is rr_ptr.
   always_comb begin
      others_waiting  = |bus.reqs[NUM_REQS-1:1];
      starve_override = PRIO0_EN && bus.reqs[0] && others_waiting &&
                        (prio_cnt_reg == STARVE_MAX);
      prio_win        = PRIO0_EN && bus.reqs[0] && !starve_override;
      scan_mask       = bus.reqs;
      if (starve_override) begin
         scan_mask[0] = 1'b0;
      end
      rotated  = NUM_REQS'({scan_mask, scan_mask} >> rr_ptr_reg);
      rr_found = 1'b0;
      rr_sum   = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
         if (!rr_found && rotated[k]) begin
            rr_found = 1'b1;
            rr_sum   = {1'b0, rr_ptr_reg} + PW'(k);
         end
      end
      rr_id      = (rr_sum >= PW'(NUM_REQS)) ? IDW'(rr_sum - PW'(NUM_REQS)) : IDW'(rr_sum);
      win_id     = prio_win ? '0 : rr_id;
      owner_done = !bus.reqs[owner_reg] || bus.lasts[owner_reg];
   end

   for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_id == IDW'(gi));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         grants_reg   <= '0;
         busy_reg     <= 1'b0;
         owner_reg    <= '0;
         timeout_reg  <= 1'b0;
         rr_ptr_reg   <= IDW'(1);
         prio_cnt_reg <= '0;
`ifdef WB_ARB_TIMEOUT_EN
         hold_cnt_reg <= '0;
`endif
      end else begin
         timeout_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (|bus.reqs) begin
                  state_reg  <= HOLD;
                  grants_reg <= win_onehot;
                  busy_reg   <= 1'b1;
                  owner_reg  <= win_id;
`ifdef WB_ARB_TIMEOUT_EN
                  hold_cnt_reg <= '0;
`endif
                  if (prio_win) begin
                     if (!others_waiting) begin
                        prio_cnt_reg <= '0;
                     end else if (prio_cnt_reg != STARVE_MAX) begin
                        prio_cnt_reg <= prio_cnt_reg + PCW'(1);
                     end
                  end else begin
                     rr_ptr_reg <= next_id(win_id);
                     if (win_id != '0) begin
                        prio_cnt_reg <= '0;
                     end
                  end
               end
            end
            HOLD: begin
               if (owner_done) begin
                  state_reg  <= IDLE;
                  grants_reg <= '0;
                  busy_reg   <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
               end else if (hold_cnt_reg == HCW'(MAX_HOLD - 1)) begin
                  // Forced release also moves the pointer past a priority owner.
                  state_reg   <= IDLE;
                  grants_reg  <= '0;
                  busy_reg    <= 1'b0;
                  timeout_reg <= 1'b1;
                  rr_ptr_reg  <= next_id(owner_reg);
               end else begin
                  hold_cnt_reg <= hold_cnt_reg + HCW'(1);
`endif
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.grants       = grants_reg;
   assign bus.busy         = busy_reg;
   assign bus.owner_id     = owner_reg;
   assign bus.timeout_flag = timeout_reg;
endmodule

// File: tb/tb_wb_pkt_scheduler.sv
// Self-checking bench for wb_pkt_scheduler: directed scenarios plus a random
// phase, all checked cycle by cycle against a transaction-level model.
module tb_wb_pkt_scheduler;
   localparam int N     = 5;
   localparam int LIMIT = 4;
   localparam int MAXH  = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   wb_pkt_scheduler_if #(.NUM_REQS(N)) bus ();

   wb_pkt_scheduler #(
      .NUM_REQS(N), .HIGH_PRIO0(1), .STARVE_LIMIT(LIMIT), .MAX_HOLD(MAXH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Model state: owner -1 means no grant held.
   int m_owner = -1;
   int m_last  = 0;
   int m_ptr   = 1;
   int m_cnt   = 0;
   int m_held  = 0;
   int m_rel   = -1;
   bit m_to    = 0;

   int order_q[$];
   int exp_q[$];
   int gcyc[N];
   int to_pulses = 0;
   bit prev_busy = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int scan(input logic [N-1:0] r, input int from, input bit skip0);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (from + k) % N;
         if (r[i] && !(skip0 && i == 0)) return i;
      end
      return -1;
   endfunction

   task automatic model_step();
      logic [N-1:0] r;
      logic [N-1:0] l;
      bit others;
      int w;
      r = bus.reqs;
      l = bus.lasts;
      m_to = 0;
      m_rel = -1;
      if (reset) begin
         m_owner = -1; m_last = 0; m_ptr = 1; m_cnt = 0; m_held = 0;
         return;
      end
      if (m_owner < 0) begin
         if (r != '0) begin
            others = (r >> 1) != '0;
            if (r[0] && others && m_cnt == LIMIT) begin
               w = scan(r, m_ptr, 1'b1); m_cnt = 0; m_ptr = (w + 1) % N;
            end else if (r[0]) begin
               w = 0; m_cnt = others ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
            end else begin
               w = scan(r, m_ptr, 1'b0); m_cnt = 0; m_ptr = (w + 1) % N;
            end
            m_owner = w; m_last = w; m_held = 0;
         end
      end else if (!r[m_owner] || l[m_owner]) begin
         m_rel = m_owner; m_owner = -1;
`ifdef WB_ARB_TIMEOUT_EN
      end else if (m_held == MAXH - 1) begin
         m_to = 1; m_ptr = (m_owner + 1) % N; m_rel = m_owner; m_owner = -1;
`endif
      end else begin
         m_held++;
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      chk("grants", 32'(bus.grants), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("busy", 32'(bus.busy), (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("owner_id", 32'(bus.owner_id), 32'(m_last));
      chk("timeout_flag", 32'(bus.timeout_flag), 32'(m_to));
      if (bus.busy && !prev_busy) order_q.push_back(int'(bus.owner_id));
      prev_busy = bus.busy;
      if (bus.timeout_flag) to_pulses++;
      for (int i = 0; i < N; i++) if (bus.grants[i]) gcyc[i]++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.reqs = '0;
      bus.lasts = '0;
      cyc();
      cyc();
      reset = 1'b0;
      order_q.delete();
      for (int i = 0; i < N; i++) gcyc[i] = 0;
      to_pulses = 0;
   endtask

   task automatic chk_order(input string tag);
      for (int k = 0; k < exp_q.size(); k++) begin
         chk(tag, (order_q.size() > k) ? 32'(order_q[k]) : 32'hffffffff, 32'(exp_q[k]));
      end
   endtask

   initial begin
      logic [N-1:0] r;
      logic [N-1:0] l;
      bus.reqs = '0;
      bus.lasts = '0;

      // Idle after reset
      do_reset();
      for (int t = 0; t < 10; t++) cyc();
      chk("idle_no_grant", 32'(order_q.size()), 32'd0);

      // Single requester, last on the 4th granted cycle, then pointer at 3
      do_reset();
      bus.reqs = 5'b00100;
      for (int t = 0; t < 4; t++) cyc();
      bus.lasts = 5'b00100;
      cyc();
      bus.lasts = 5'b00000;
      bus.reqs = 5'b01010;
      for (int t = 0; t < 3; t++) cyc();
      chk("burst_len_req2", 32'(gcyc[2]), 32'd4);
      exp_q = '{2, 3};
      chk_order("ptr_after_2");

      // Round-robin over 1..4 with single-beat bursts
      do_reset();
      bus.reqs = 5'b11110;
      bus.lasts = 5'b11111;
      for (int t = 0; t < 12; t++) cyc();
      exp_q = '{1, 2, 3, 4, 1};
      chk_order("rr_order");

      // Starvation bound on the priority lane
      do_reset();
      bus.reqs = 5'b01001;
      bus.lasts = 5'b11111;
      for (int t = 0; t < 24; t++) cyc();
      exp_q = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 3};
      chk_order("starve_order");

      // Owner drops request mid-burst; pending requester follows; reset mid-hold
      do_reset();
      bus.reqs = 5'b10100;
      bus.lasts = 5'b00000;
      for (int t = 0; t < 3; t++) cyc();
      bus.reqs = 5'b10000;
      for (int t = 0; t < 4; t++) cyc();
      exp_q = '{2, 4};
      chk_order("drop_then_4");
      chk("drop_len_req2", 32'(gcyc[2]), 32'd3);
      reset = 1'b1;
      cyc();
      chk("reset_mid_hold", 32'(bus.grants), 32'd0);
      reset = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
      // Forced release after MAX_HOLD cycles
      do_reset();
      bus.reqs = 5'b00110;
      bus.lasts = 5'b00000;
      for (int t = 0; t < 12; t++) cyc();
      chk("timeout_hold_len", 32'(gcyc[1]), 32'(MAXH));
      chk("timeout_pulses", 32'(to_pulses), 32'd1);
      exp_q = '{1, 2};
      chk_order("timeout_order");
`endif

      // Random traffic against the model
      do_reset();
      for (int t = 0; t < 1500; t++) begin
         r = bus.reqs;
         l = '0;
         for (int i = 0; i < N; i++) begin
            if (i == m_owner) begin
               l[i] = ($urandom_range(0, 2) == 0);
               if ($urandom_range(0, 15) == 0) r[i] = 1'b0;
            end else begin
               l[i] = 1'($urandom_range(0, 1));
               if (i == m_rel && $urandom_range(0, 1) == 1) r[i] = 1'b0;
               else if (!r[i] && $urandom_range(0, 4) == 0) r[i] = 1'b1;
            end
         end
         bus.reqs = r;
         bus.lasts = l;
         reset = (t == 700);
         cyc();
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
